// File: rtl/gamepad_scanner.sv
// ---------------------------------------------------------------------------
// gamepad_scanner
//   Host-side scanner for a 3-button multiplexed gamepad. Each frame drives
//   SELECT high, then low, and samples the shared active-low pins after each
//   phase has settled. The eight button bits it returns are active-high and
//   filtered by frame-to-frame agreement. It also produces one-cycle press
//   events and a pad-present flag.
//
// Parameters
//   SETTLE : cycles SELECT is held per phase before sampling (>= 4)
//   PERIOD : cycles between frame starts (>= 2*SETTLE+2)
//   CW     : period counter width (2**CW > PERIOD)
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   up_in .. c_start    : raw pad pins (active-low, asynchronous to clk)
//   select              : SELECT drive to the pad
//   buttons[7:0]        : stable buttons {start,a,c,b,up,down,left,right}
//   press[7:0]          : one-cycle pulse per button 0->1 transition
//   pad_present         : last frame saw a pad (left/right low in SEL_LO)
//   frame_valid         : one-cycle pulse when a frame's results appear
// ---------------------------------------------------------------------------
module gamepad_scanner #(
  parameter int SETTLE = 4,
  parameter int PERIOD = 16384,
  parameter int CW     = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up_in,
  input  logic       down_in,
  input  logic       left_in,
  input  logic       right_in,
  input  logic       a_b,
  input  logic       c_start,
  output logic       select,
  output logic [7:0] buttons,
  output logic [7:0] press,
  output logic       pad_present,
  output logic       frame_valid
);

  typedef enum logic [1:0] {
    SEL_HI = 2'd0,
    SEL_LO = 2'd1,
    UPDATE = 2'd2,
    IDLE   = 2'd3
  } state_t;

  localparam logic [CW-1:0] HI_END = CW'(SETTLE - 1);
  localparam logic [CW-1:0] LO_END = CW'(2 * SETTLE - 1);
  localparam logic [CW-1:0] LAST   = CW'(PERIOD - 1);

  // Pin vector order: [0]up [1]down [2]left [3]right [4]a_b [5]c_start
  logic [5:0] pins_s;
  logic [5:0] sync1_r;
  logic [5:0] sync2_r;
  logic [5:0] hi_r;          // inverted SEL_HI sample
  logic [CW-1:0] cnt_r;
  state_t     state_r;
  state_t     next_state_s;
  logic       hi_cap_s;
  logic       lo_cap_s;
  logic [7:0] raw_s;
  logic       present_s;
  logic [7:0] prev_r;
  logic [7:0] buttons_r;
  logic [7:0] press_r;
  logic       pad_present_r;
  logic       frame_valid_r;
  logic       select_r;

  assign pins_s = {c_start, a_b, right_in, left_in, down_in, up_in};

  // Two-flop synchronizer; released (high) pins after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 6'b111111;
      sync2_r <= 6'b111111;
    end else begin
      sync1_r <= pins_s;
      sync2_r <= sync1_r;
    end
  end

  // Period counter: cnt_r equals the position t inside the current frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= SEL_HI;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic and sample strobes
  always_comb begin
    next_state_s = state_r;
    hi_cap_s     = 1'b0;
    lo_cap_s     = 1'b0;
    case (state_r)
      SEL_HI: begin
        if (cnt_r == HI_END) begin
          hi_cap_s     = 1'b1;
          next_state_s = SEL_LO;
        end else begin
          next_state_s = SEL_HI;
        end
      end
      SEL_LO: begin
        if (cnt_r == LO_END) begin
          lo_cap_s     = 1'b1;
          next_state_s = UPDATE;
        end else begin
          next_state_s = SEL_LO;
        end
      end
      UPDATE: begin
        next_state_s = IDLE;
      end
      IDLE: begin
        if (cnt_r == LAST) begin
          next_state_s = SEL_HI;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: begin
        next_state_s = SEL_HI;
      end
    endcase
  end

  // Raw frame: the SEL_HI sample plus the live SEL_LO pins at their sample point
  assign raw_s     = {~sync2_r[5], ~sync2_r[4], hi_r[5], hi_r[4],
                      hi_r[0], hi_r[1], hi_r[2], hi_r[3]};
  assign present_s = ~sync2_r[2] & ~sync2_r[3];

  // SEL_HI capture of the inverted pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r <= 6'b000000;
    end else if (hi_cap_s) begin
      hi_r <= ~sync2_r;
    end else begin
      hi_r <= hi_r;
    end
  end

  // SELECT drive follows the state being entered, so it is low exactly in SEL_LO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      select_r <= 1'b1;
    end else begin
      select_r <= (next_state_s != SEL_LO);
    end
  end

  // Frame update, committed on the SEL_LO sample edge so results show in UPDATE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buttons_r     <= 8'h00;
      press_r       <= 8'h00;
      prev_r        <= 8'h00;
      pad_present_r <= 1'b0;
      frame_valid_r <= 1'b0;
    end else if (lo_cap_s) begin
      frame_valid_r <= 1'b1;
      pad_present_r <= present_s;
      if (!present_s) begin
        buttons_r <= 8'h00;
        press_r   <= 8'h00;
        prev_r    <= 8'h00;
      end else if (raw_s == prev_r) begin
        buttons_r <= raw_s;
        press_r   <= raw_s & ~buttons_r;
        prev_r    <= raw_s;
      end else begin
        buttons_r <= buttons_r;
        press_r   <= 8'h00;
        prev_r    <= raw_s;
      end
    end else begin
      frame_valid_r <= 1'b0;
      press_r       <= 8'h00;
      pad_present_r <= pad_present_r;
      buttons_r     <= buttons_r;
      prev_r        <= prev_r;
    end
  end

  assign select      = select_r;
  assign buttons     = buttons_r;
  assign press       = press_r;
  assign pad_present = pad_present_r;
  assign frame_valid = frame_valid_r;

endmodule

// File: tb/tb_gamepad_scanner.sv
// ---------------------------------------------------------------------------
// tb_gamepad_scanner
//   Drives gamepad_scanner (SETTLE=4, PERIOD=32) through a behavioural pad
//   that answers SELECT, and compares every output on every cycle against a
//   frame-level reference model of the scanner.
// ---------------------------------------------------------------------------
module tb_gamepad_scanner;

  localparam int SETTLE = 4;
  localparam int PERIOD = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_in, down_in, left_in, right_in, a_b, c_start;
  logic       select;
  logic [7:0] buttons, press;
  logic       pad_present, frame_valid;

  // Pad behaviour: held buttons (active-high, scanner bit order) and connection
  logic [7:0] pad_p = 8'h00;
  logic       pad_c = 1'b0;

  int tests = 0;
  int fails = 0;
  int t     = 0;

  // Reference model state
  logic [7:0] m_btn   = 8'h00;
  logic [7:0] m_prev  = 8'h00;
  logic [7:0] m_press = 8'h00;
  logic       m_pres  = 1'b0;

  gamepad_scanner #(.SETTLE(SETTLE), .PERIOD(PERIOD), .CW(6)) dut (
    .clk(clk), .rst(rst),
    .up_in(up_in), .down_in(down_in), .left_in(left_in), .right_in(right_in),
    .a_b(a_b), .c_start(c_start),
    .select(select), .buttons(buttons), .press(press),
    .pad_present(pad_present), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  // Pad: SELECT=1 reports directions, B, C; SELECT=0 forces left/right low
  // and reports A, Start.
  always_comb begin
    up_in = 1'b1; down_in = 1'b1; left_in = 1'b1; right_in = 1'b1;
    a_b = 1'b1; c_start = 1'b1;
    if (pad_c) begin
      up_in   = ~pad_p[3];
      down_in = ~pad_p[2];
      if (select) begin
        left_in  = ~pad_p[1];
        right_in = ~pad_p[0];
        a_b      = ~pad_p[4];
        c_start  = ~pad_p[5];
      end else begin
        left_in  = 1'b0;
        right_in = 1'b0;
        a_b      = ~pad_p[6];
        c_start  = ~pad_p[7];
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h t=%0d", tag, got, exp, t);
    end
  endtask

  // One clock; at the end-of-frame point apply the frame rules to the model,
  // then compare all outputs.
  task automatic step();
    int pos;
    @(posedge clk);
    #1;
    t++;
    pos = t % PERIOD;
    m_press = 8'h00;
    if (pos == 2 * SETTLE) begin
      m_pres = pad_c;
      if (!pad_c) begin
        m_btn  = 8'h00;
        m_prev = 8'h00;
      end else begin
        if (pad_p == m_prev) begin
          m_press = pad_p & ~m_btn;
          m_btn   = pad_p;
        end
        m_prev = pad_p;
      end
    end
    chk("select", {7'd0, select}, {7'd0, !(pos >= SETTLE && pos < 2 * SETTLE)});
    chk("frame_valid", {7'd0, frame_valid}, {7'd0, pos == 2 * SETTLE});
    chk("buttons", buttons, m_btn);
    chk("press", press, m_press);
    chk("pad_present", {7'd0, pad_present}, {7'd0, m_pres});
  endtask

  // Hold a pad state for n whole frames, starting mid-IDLE (pos 16)
  task automatic frames(input logic [7:0] p, input logic c, input int n);
    pad_p = c ? p : 8'h00;
    pad_c = c;
    for (int f = 0; f < n; f++) begin
      for (int k = 0; k < PERIOD; k++) step();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_select"}, {7'd0, select}, 8'd1);
    chk({tag, "_buttons"}, buttons, 8'h00);
    chk({tag, "_press"}, press, 8'h00);
    chk({tag, "_frame_valid"}, {7'd0, frame_valid}, 8'd0);
    chk({tag, "_pad_present"}, {7'd0, pad_present}, 8'd0);
  endtask

  initial begin
    logic [7:0] rp;
    logic       rc;
    int         hold;

    // Reset with all pins released
    rst = 1'b1;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    rst = 1'b0;
    t   = 0;
    for (int k = 0; k < PERIOD / 2; k++) step();

    // No pad attached
    frames(8'h00, 1'b0, 2);
    // A held over frames: accepted on the 2nd frame, one press
    frames(8'h40, 1'b1, 3);
    // Clear, then Up for a single frame only
    frames(8'h00, 1'b1, 2);
    frames(8'h08, 1'b1, 1);
    frames(8'h00, 1'b1, 2);
    // B+C held two frames, then released
    frames(8'h30, 1'b1, 2);
    frames(8'h00, 1'b1, 3);

    // Random pad states held 1..3 frames, occasionally unplugged
    for (int i = 0; i < 25; i++) begin
      rp   = 8'($urandom_range(0, 255));
      rc   = ($urandom_range(0, 4) != 0);
      hold = $urandom_range(1, 3);
      frames(rp, rc, hold);
    end

    // Up accepted, then reset at t=6 of a frame
    frames(8'h08, 1'b1, 2);
    for (int k = 0; k < PERIOD - 10; k++) step();
    chk("pre_reset_buttons", buttons, 8'h08);
    chk("pre_reset_pos", 8'(t % PERIOD), 8'd6);
    rst = 1'b1;
    #1;
    check_reset_outputs("midframe_reset");
    m_btn  = 8'h00;
    m_prev = 8'h00;
    m_pres = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    t   = 0;
    for (int k = 0; k < PERIOD / 2; k++) step();
    frames(8'h08, 1'b1, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
